// File: rtl/spart_driver.sv
// Processor-side SPART driver: programs the baud divisor selected by br_cfg,
// then echoes received bytes back to the transmitter through a 4-entry FIFO.
module spart_driver #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       cfg_done,
    output logic [2:0] fifo_count
);

    typedef enum logic [2:0] {WR_DBL, WR_DBH, IDLE, RD_RX, WR_TX, GAP} state_t;

    state_t      state_q, state_d;
    logic        gap_q, gap_d;
    logic [1:0]  br_meta_q, br_meta_d;
    logic [1:0]  br_sync_q, br_sync_d;
    logic [1:0]  br_applied_q, br_applied_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        push, pop;
    logic [7:0]  bus_out;
    logic [7:0]  fifo_mem [4];
    logic [15:0] div_table [4];

    // Divisors are elaboration-time constants, so the select only drives a small mux.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_div
            localparam int BAUD = 4800 << gi;
            localparam int DIV  = CLK_HZ / BAUD;
            assign div_table[gi] = 16'(DIV);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WR_DBL;
            gap_q        <= 1'b0;
            br_meta_q    <= 2'b00;
            br_sync_q    <= 2'b00;
            br_applied_q <= 2'b00;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            br_meta_q    <= br_meta_d;
            br_sync_q    <= br_sync_d;
            br_applied_q <= br_applied_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= databus;
        end
    end

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        br_meta_d    = br_cfg;
        br_sync_d    = br_meta_q;
        br_applied_d = br_applied_q;
        push         = 1'b0;
        pop          = 1'b0;
        case (state_q)
            WR_DBL: begin
                br_applied_d = br_sync_q;
                state_d      = WR_DBH;
            end
            WR_DBH: state_d = IDLE;
            IDLE: begin
                if (br_sync_q != br_applied_q) begin
                    state_d = WR_DBL;
                end else if (rda && count_q != 3'd4) begin
                    state_d = RD_RX;
                end else if (tbr && count_q != 3'd0) begin
                    state_d = WR_TX;
                end
            end
            RD_RX: begin
                push    = 1'b1;
                gap_d   = 1'b0;
                state_d = GAP;
            end
            WR_TX: begin
                pop     = 1'b1;
                gap_d   = 1'b0;
                state_d = GAP;
            end
            GAP: begin
                // Two idle cycles give the SPART time to update rda/tbr.
                gap_d = 1'b1;
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = WR_DBL;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + 2'(push);
        rd_ptr_d = rd_ptr_q + 2'(pop);
        count_d  = count_q;
        if (push) begin
            count_d = count_q + 3'd1;
        end else if (pop) begin
            count_d = count_q - 3'd1;
        end
    end

    // Access strobes are gated by rst so the bus goes idle the instant reset asserts.
    always_comb begin
        iocs     = 1'b0;
        iorw     = 1'b1;
        ioaddr   = 2'b01;
        bus_out  = 8'h00;
        cfg_done = (state_q != WR_DBL) && (state_q != WR_DBH);
        if (rst) begin
            case (state_q)
                WR_DBL: begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = 2'b10;
                    bus_out = div_table[br_sync_q][7:0];
                end
                WR_DBH: begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = 2'b11;
                    bus_out = div_table[br_applied_q][15:8];
                end
                RD_RX: begin
                    iocs   = 1'b1;
                    ioaddr = 2'b00;
                end
                WR_TX: begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = 2'b00;
                    bus_out = fifo_mem[rd_ptr_q];
                end
                default: ;
            endcase
        end
    end

    assign databus    = (iocs && !iorw) ? bus_out : 8'hzz;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a SPART stand-in feeds receive bytes, and a transaction-level
// model (byte queues plus a two-edge select delay) checks every bus cycle.
module tb_spart_driver;

    localparam int CLK_HZ = 50_000_000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda, tbr;
    logic       iocs, iorw, cfg_done;
    logic [1:0] ioaddr;
    logic [2:0] fifo_count;
    wire  [7:0] databus;
    logic [7:0] rx_head;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    bit         rx_en = 0, tbr_en = 0;
    int         n_pushed = 0;

    spart_driver #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
        .cfg_done(cfg_done), .fifo_count(fifo_count)
    );

    // SPART side of the bus: supplies the oldest received byte on a buffer read.
    assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_head : 8'hzz;

    always #5 clk = ~clk;

    task automatic chkv(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int div_of(input logic [1:0] sel);
        return (CLK_HZ / (4800 << sel)) & 'hFFFF;
    endfunction

    task automatic push_rx(input logic [7:0] b);
        rx_q.push_back(b);
        n_pushed++;
    endtask

    // Transaction monitor / reference model, evaluated mid-cycle.
    initial begin
        logic [1:0] sync_hist [2];
        logic [1:0] applied;
        bit         dbl_seen, have_last, rx_pop;
        int         cyc, last_cyc;
        sync_hist = '{2'b00, 2'b00};
        applied = 2'b00; dbl_seen = 0; have_last = 0; rx_pop = 0; cyc = 0; last_cyc = 0;
        rda = 1'b0; tbr = 1'b0; rx_head = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chkv("reset_bus", int'({iocs, iorw, ioaddr}), 'b0101);
                chkv("reset_cfg_done", int'(cfg_done), 0);
                chkv("reset_fifo_count", int'(fifo_count), 0);
                exp_q.delete();
                dbl_seen = 0; have_last = 0;
            end else begin
                chkv("fifo_count", int'(fifo_count), exp_q.size());
                if (dbl_seen) chkv("dbh_follows_dbl", int'({iocs, iorw, ioaddr}), 'b1011);
                dbl_seen = 0;
                if (!iocs) begin
                    chkv("idle_bus", int'({iorw, ioaddr}), 'b101);
                    chkv("idle_cfg_done", int'(cfg_done), 1);
                end else if (!iorw && ioaddr == 2'b10) begin
                    chkv("div_lo", int'(databus), div_of(sync_hist[1]) & 'hFF);
                    chkv("dbl_cfg_done", int'(cfg_done), 0);
                    if (have_last) chkv("spacing", int'(cyc - last_cyc >= 4), 1);
                    applied = sync_hist[1]; dbl_seen = 1; have_last = 0;
                end else if (!iorw && ioaddr == 2'b11) begin
                    chkv("div_hi", int'(databus), div_of(applied) >> 8);
                    chkv("dbh_cfg_done", int'(cfg_done), 0);
                end else if (ioaddr == 2'b00) begin
                    chkv("data_cfg_done", int'(cfg_done), 1);
                    if (have_last) chkv("spacing", int'(cyc - last_cyc >= 4), 1);
                    have_last = 1; last_cyc = cyc;
                    if (iorw) begin
                        chkv("read_not_full", int'(exp_q.size() < 4), 1);
                        chkv("read_has_rx", int'(rx_q.size() > 0), 1);
                        if (rx_q.size() > 0) begin
                            exp_q.push_back(rx_q[0]);
                            rx_pop = 1;
                        end
                    end else begin
                        chkv("write_not_empty", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            chkv("tx_byte", int'(databus), int'(exp_q[0]));
                            void'(exp_q.pop_front());
                        end
                        tx_log.push_back(databus);
                    end
                end else begin
                    chkv("legal_access", int'({iocs, iorw, ioaddr}), 'b1100);
                end
            end
            @(posedge clk);
            if (!rst) sync_hist = '{2'b00, 2'b00};
            else begin
                sync_hist[1] = sync_hist[0];
                sync_hist[0] = br_cfg;
            end
            cyc++;
            #1;
            if (rx_pop && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_pop = 0;
            rda = rx_en && rx_q.size() > 0;
            tbr = tbr_en;
            rx_head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        end
    end

    task automatic wait_access(input int budget, output bit got);
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #2;
            if (iocs) got = 1;
        end
    endtask

    task automatic wait_write(input int budget, output bit got);
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #2;
            if (iocs && !iorw && ioaddr == 2'b00) got = 1;
        end
    endtask

    task automatic wait_count(input int target, input int budget, output bit got);
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #2;
            if (int'(fifo_count) == target) got = 1;
        end
    endtask

    task automatic drain(input string name);
        bit got;
        got = 0;
        rx_en = 1; tbr_en = 1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk); #2;
            if (rx_q.size() == 0 && exp_q.size() == 0 && fifo_count == 3'd0 && !iocs) got = 1;
        end
        chkv(name, int'(got), 1);
    endtask

    initial begin
        bit got;
        int base;
        rst = 1'b0; br_cfg = 2'b01;

        // Reset programming: the synchronizer starts at 00, so 4800 is written first,
        // then the live select (9600) once it has crossed the two flops.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #2;
        chkv("c1_bus", int'({iocs, iorw, ioaddr}), 'b1010);
        chkv("c1_data", int'(databus), 'hB0);
        chkv("c1_cfg_done", int'(cfg_done), 0);
        @(negedge clk); #2;
        chkv("c2_bus", int'({iocs, iorw, ioaddr}), 'b1011);
        chkv("c2_data", int'(databus), 'h28);
        @(negedge clk); #2;
        chkv("c3_idle", int'({iocs, cfg_done}), 'b01);
        @(negedge clk); #2;
        chkv("c4_bus", int'({iocs, iorw, ioaddr}), 'b1010);
        chkv("c4_data", int'(databus), 'h58);
        @(negedge clk); #2;
        chkv("c5_data", int'(databus), 'h14);
        chkv("c5_cfg_done", int'(cfg_done), 0);
        @(negedge clk); #2;
        chkv("c6_idle", int'({iocs, cfg_done}), 'b01);

        // Echo with read latency of one cycle after rda is seen in IDLE.
        push_rx(8'h41); rx_en = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #2;
            if (rda) got = 1;
        end
        chkv("echo_rda_timeout", int'(got), 1);
        @(negedge clk); #2;
        chkv("echo_read_strobe", int'({iocs, iorw, ioaddr}), 'b1100);
        @(negedge clk); #2;
        chkv("echo_count_1", int'(fifo_count), 1);
        tbr_en = 1;
        wait_write(20, got);
        chkv("echo_write_timeout", int'(got), 1);
        chkv("echo_write_data", int'(databus), 'h41);
        @(negedge clk); #2;
        chkv("echo_count_0", int'(fifo_count), 0);

        // Full FIFO holds rda pending; the fifth byte is read once a slot frees.
        tbr_en = 0;
        for (int k = 0; k < 5; k++) push_rx(8'(8'h10 + k));
        wait_count(4, 200, got);
        chkv("full_timeout", int'(got), 1);
        repeat (30) @(negedge clk);
        #2;
        chkv("full_hold_count", int'(fifo_count), 4);
        chkv("full_pending", rx_q.size(), 1);
        tbr_en = 1;
        for (int k = 0; k < 5; k++) begin
            wait_write(100, got);
            chkv("full_write_timeout", int'(got), 1);
            chkv("full_write_order", int'(databus), 'h10 + k);
        end
        drain("full_drain");

        // Priority: read wins when rda and tbr rise together.
        tbr_en = 0;
        push_rx(8'hA0); push_rx(8'hA1);
        wait_count(2, 100, got);
        chkv("prio_fill_timeout", int'(got), 1);
        rx_en = 0;
        push_rx(8'hA2);
        repeat (5) @(negedge clk);
        #2;
        rx_en = 1; tbr_en = 1;
        wait_access(20, got);
        chkv("prio_timeout", int'(got), 1);
        chkv("prio_read_first", int'({iocs, iorw, ioaddr}), 'b1100);
        wait_write(20, got);
        chkv("prio_write_oldest", int'(databus), 'hA0);
        drain("prio_drain");

        // Baud change with FIFO full and rda pending: reprogram takes the bus first.
        tbr_en = 0;
        for (int k = 0; k < 5; k++) push_rx(8'(8'h50 + k));
        wait_count(4, 200, got);
        chkv("baud_fill_timeout", int'(got), 1);
        repeat (5) @(negedge clk);
        #2;
        br_cfg = 2'b11;
        wait_access(20, got);
        chkv("baud_timeout", int'(got), 1);
        chkv("baud_lo_bus", int'({iocs, iorw, ioaddr, cfg_done}), 'b10100);
        chkv("baud_lo_data", int'(databus), 'h16);
        @(negedge clk); #2;
        chkv("baud_hi_bus", int'({iocs, iorw, ioaddr, cfg_done}), 'b10110);
        chkv("baud_hi_data", int'(databus), 'h05);
        @(negedge clk); #2;
        chkv("baud_done", int'(cfg_done), 1);
        chkv("baud_fifo_intact", int'(fifo_count), 4);
        drain("baud_drain");

        // Randomized traffic and select changes; every byte must come back out.
        base = tx_log.size();
        n_pushed = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk); #2;
            if ($urandom_range(7) == 0 && rx_q.size() < 6) push_rx(8'($urandom));
            if ($urandom_range(15) == 0) rx_en = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) tbr_en = ($urandom_range(2) != 0);
            if ($urandom_range(199) == 0) br_cfg = 2'($urandom);
        end
        br_cfg = 2'b10;
        drain("rand_drain");
        chkv("rand_no_drop", tx_log.size() - base, n_pushed);

        // Reset during a transmit write.
        tbr_en = 0;
        push_rx(8'hC0); push_rx(8'hC1);
        wait_count(2, 100, got);
        chkv("rst_fill_timeout", int'(got), 1);
        tbr_en = 1;
        wait_write(50, got);
        chkv("rst_write_timeout", int'(got), 1);
        rst = 1'b0;
        #1;
        chkv("rst_bus_idle", int'({iocs, iorw, ioaddr}), 'b0101);
        chkv("rst_fifo_count", int'(fifo_count), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tbr_en = 0; rx_en = 0;
        @(negedge clk); #2;
        chkv("rst_c1_bus", int'({iocs, iorw, ioaddr}), 'b1010);
        chkv("rst_c1_data", int'(databus), 'hB0);
        @(negedge clk); #2;
        chkv("rst_c2_data", int'(databus), 'h28);
        wait_access(10, got);
        chkv("rst_reprog_timeout", int'(got), 1);
        chkv("rst_reprog_lo", int'(databus), 'h2C);
        @(negedge clk); #2;
        chkv("rst_reprog_hi", int'(databus), 'h0A);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
